// File: rtl/rv32i_types.sv
// rv32i_types: shared predictor constants, prediction bundle and counter helper
package rv32i_types;
  localparam int BTB_ENTRIES = 16;
  localparam int BHT_ENTRIES = 64;
  localparam int BTB_IDX_W = 4;
  localparam int BHT_IDX_W = 6;
  localparam logic [1:0] BHT_RESET = 2'b01;
  typedef struct packed {
    logic        br_pred;
    logic        btb_hit;
    logic [31:0] btb_target;
    logic [31:0] pc_br_not_taken;
  } br_pred_sigs;
  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
    return taken ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
  endfunction
endpackage

// File: rtl/br_bht.sv
// br_bht: untagged table of 2-bit saturating direction counters
module br_bht
  import rv32i_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BHT_IDX_W-1:0] rd_idx,
  output logic [1:0]           rd_ctr,
  input  logic                 upd_en,
  input  logic [BHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_is_jump,
  input  logic                 upd_taken
);
  logic [1:0] ctr_q [BHT_ENTRIES];
  logic [1:0] ctr_d [BHT_ENTRIES];
  assign rd_ctr = ctr_q[rd_idx];
  always_comb begin
    ctr_d = ctr_q;
    if (upd_en) ctr_d[upd_idx] = upd_is_jump ? 2'b11 : sat_update(ctr_q[upd_idx], upd_taken);
  end
  always_ff @(posedge clk) begin
    if (!rst) ctr_q <= '{default: BHT_RESET};
    else ctr_q <= ctr_d;
  end
endmodule

// File: rtl/br_predictor.sv
// br_predictor: BTB + BHT fetch predictor with EX-side training and perf counters
module br_predictor
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i_IF,
  input  logic        stall_i,
  output br_pred_sigs br_pred_sigs_o,
  output logic [31:0] pred_pc_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_is_jump_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_btb_hit_i,
  input  logic        upd_br_pred_i,
  input  logic [31:0] upd_pred_target_i,
  output logic [31:0] perf_lookups_o,
  output logic [31:0] perf_dir_miss_o,
  output logic [31:0] perf_tgt_miss_o
);
  logic        valid_q [BTB_ENTRIES];
  logic        valid_d [BTB_ENTRIES];
  logic [25:0] tag_q   [BTB_ENTRIES];
  logic [25:0] tag_d   [BTB_ENTRIES];
  logic [31:0] tgt_q   [BTB_ENTRIES];
  logic [31:0] tgt_d   [BTB_ENTRIES];
  logic [31:0] lookups_q, lookups_d, dir_miss_q, dir_miss_d, tgt_miss_q, tgt_miss_d;
  logic [BTB_IDX_W-1:0] rd_idx, wr_idx;
  logic [1:0]  rd_ctr;
  logic        btb_wr, pred_taken, dir_miss, tgt_miss;
  assign rd_idx = pc_i_IF[5:2];
  assign wr_idx = upd_pc_i[5:2];
  br_bht u_bht (
    .clk         (clk),
    .rst         (rst),
    .rd_idx      (pc_i_IF[7:2]),
    .rd_ctr      (rd_ctr),
    .upd_en      (upd_valid_i),
    .upd_idx     (upd_pc_i[7:2]),
    .upd_is_jump (upd_is_jump_i),
    .upd_taken   (upd_taken_i)
  );
  always_comb begin
    br_pred_sigs_o.btb_hit         = valid_q[rd_idx] && (tag_q[rd_idx] == pc_i_IF[31:6]);
    br_pred_sigs_o.br_pred         = rd_ctr[1];
    br_pred_sigs_o.btb_target      = tgt_q[rd_idx];
    br_pred_sigs_o.pc_br_not_taken = pc_i_IF + 32'd4;
    pred_pc_o = (br_pred_sigs_o.btb_hit && br_pred_sigs_o.br_pred) ? br_pred_sigs_o.btb_target
                                                                    : br_pred_sigs_o.pc_br_not_taken;
  end
  // Not-taken outcomes never disturb the BTB; taken ones evict whatever shares the index.
  assign btb_wr = upd_valid_i && upd_taken_i;
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (btb_wr) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = upd_pc_i[31:6];
      tgt_d[wr_idx]   = upd_target_i;
    end
  end
  assign pred_taken = upd_btb_hit_i && upd_br_pred_i;
  assign dir_miss   = upd_valid_i && (pred_taken != upd_taken_i);
  assign tgt_miss   = upd_valid_i && pred_taken && upd_taken_i && (upd_pred_target_i != upd_target_i);
  assign lookups_d  = lookups_q + {31'd0, !stall_i};
  assign dir_miss_d = dir_miss_q + {31'd0, dir_miss};
  assign tgt_miss_d = tgt_miss_q + {31'd0, tgt_miss};
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= '{default: 1'b0};
      lookups_q  <= '0;
      dir_miss_q <= '0;
      tgt_miss_q <= '0;
    end else begin
      valid_q    <= valid_d;
      lookups_q  <= lookups_d;
      dir_miss_q <= dir_miss_d;
      tgt_miss_q <= tgt_miss_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= tag_d;
      tgt_q <= tgt_d;
    end
  end
  assign perf_lookups_o  = lookups_q;
  assign perf_dir_miss_o = dir_miss_q;
  assign perf_tgt_miss_o = tgt_miss_q;
endmodule
